// File: rtl/wb_pkg.sv
// Shared constants and the entry record for the register write queue.
//   DEPTH  : default number of queue entries (power of two)
//   WIDTH  : default write-data width
//   IDX_W  : destination register index width (drives a 3-to-8 decoder)
//   CNT_W  : width of the occupancy count (holds 0..DEPTH)
//   entry_t: one queued write (index, data)
package wb_pkg;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned IDX_W = 3;
    localparam int unsigned CNT_W = 3;

    typedef struct packed {
        logic [IDX_W-1:0] index;
        logic [WIDTH-1:0] data;
    } entry_t;

endpackage

// File: rtl/wb_queue_mem.sv
// Entry storage and read/write pointers for wb_write_queue.
// Ports:
//   clock, reset_n     : clock, asynchronous active-low reset (pointers only)
//   push, pop          : advance write / read pointer (callers gate these)
//   flush              : return both pointers to zero, overrides push/pop
//   wr_index, wr_data  : entry written at the write pointer on push
//   rd_index, rd_data  : current head entry (combinational read)
module wb_queue_mem
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = wb_pkg::DEPTH,
    parameter int unsigned WIDTH = wb_pkg::WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [IDX_W-1:0] wr_index,
    input  logic [WIDTH-1:0] wr_data,
    output logic [IDX_W-1:0] rd_index,
    output logic [WIDTH-1:0] rd_data
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [IDX_W+WIDTH-1:0] store [DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;

    // Explicit wrap keeps the DEPTH=1 case correct where PTR_W exceeds log2.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
        end
    end

    // Storage contents are don't-care until written, so no reset here.
    always_ff @(posedge clock) begin
        if (push && !flush) store[wr_ptr] <= {wr_index, wr_data};
    end

    assign {rd_index, rd_data} = store[rd_ptr];

endmodule

// File: rtl/wb_write_queue.sv
// Register-file write queue: buffers (index, data) write requests and drains
// them one per cycle onto a 3-to-8 decoder select/enable plus data bus.
// Ports:
//   clock, reset_n        : clock, asynchronous active-low reset
//   in_valid/in_ready     : request handshake; in_ready = count < DEPTH
//   in_index, in_data     : destination index (0 = discard) and write data
//   stall                 : holds the queue, no draining while high
//   flush                 : synchronous discard of queued and in-flight writes
//   out_sel0..2           : registered head index bits to decoder in0..in2
//   out_enable            : decoder enable, one cycle per drained write
//   out_data              : registered data accompanying out_enable
//   count                 : number of stored entries (0..DEPTH)
module wb_write_queue
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = wb_pkg::DEPTH,
    parameter int unsigned WIDTH = wb_pkg::WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IDX_W-1:0] in_index,
    input  logic [WIDTH-1:0] in_data,
    input  logic             stall,
    input  logic             flush,
    output logic             out_sel0,
    output logic             out_sel1,
    output logic             out_sel2,
    output logic             out_enable,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] count
);

    logic             push;
    logic             pop;
    logic [IDX_W-1:0] head_index;
    logic [WIDTH-1:0] head_data;
    logic [IDX_W-1:0] sel_q;

    // Ready depends on registered count only, so a full queue stays closed
    // even on an edge where it is also popping.
    assign in_ready = (32'(count) < DEPTH);

    // Index 0 completes the handshake but is never stored.
    assign push = in_valid && in_ready && !flush && (in_index != '0);
    assign pop  = (count != '0) && !stall && !flush;

    wb_queue_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_mem (
        .clock    (clock),
        .reset_n  (reset_n),
        .push     (push),
        .pop      (pop),
        .flush    (flush),
        .wr_index (in_index),
        .wr_data  (in_data),
        .rd_index (head_index),
        .rd_data  (head_data)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // pop is already low under flush, so the enable pulse is suppressed too.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_enable <= 1'b0;
            sel_q      <= '0;
            out_data   <= '0;
        end else begin
            out_enable <= pop;
            if (pop) begin
                sel_q    <= head_index;
                out_data <= head_data;
            end
        end
    end

    assign out_sel0 = sel_q[0];
    assign out_sel1 = sel_q[1];
    assign out_sel2 = sel_q[2];

endmodule
